trace_trig_sequencer: RTL and testbench
=======================================

Name: trace_trig_sequencer

Overview:
- Capture-trigger controller between the trace matcher / M3 GPIO trigger and the board trig_out pin.
- Sequences one arm session: wait for trigger event, apply programmable delay, emit a programmable-width pulse, repeat for N triggers, then report done.
- Owns the soft-trigger passthrough mux and drives the arm/capturing LED status.
- Sits in the trace_clk_in domain beside trace_top. All USB-side configuration arrives already synchronized.

Parameters:
- pDELAY_WIDTH, 16, width of trigger delay count (cycles)
- pPULSE_WIDTH, 16, width of trigger pulse-length count (cycles)
- pCOUNT_WIDTH, 8, width of triggers-per-arm count and missed-event counter

Ports:
- trace_clk_in  input  1  sole clock, trace clock domain
- reset  input  1  synchronous, active-high reset
- I_arm  input  1  arm level; rising edge starts a session, low aborts
- I_soft_trig_passthru  input  1  1 = trig_out follows M3 GPIO trigger, FSM bypassed
- I_trace_trig  input  1  trigger from trace matcher (level or pulse)
- I_m3_trig  input  1  M3 GPIO trigger
- I_delay  input  pDELAY_WIDTH  cycles from event to pulse start
- I_pulse_len  input  pPULSE_WIDTH  pulse length in cycles; 0 treated as 1
- I_num_trigs  input  pCOUNT_WIDTH  triggers per arm; 0 treated as 1
- O_trig_out  output  1  registered trigger to pin
- O_arm_active  output  1  high in ARMED/DELAY/PULSE
- O_capturing  output  1  high in DELAY/PULSE
- O_done  output  1  high in DONE
- O_trig_count  output  pCOUNT_WIDTH  pulses issued this session
- O_missed  output  pCOUNT_WIDTH  events ignored while busy; saturating

Behaviour:
- Reset: all outputs 0, state IDLE, edge registers 0.
- Event = I_trace_trig high and its registered previous value low (rising edge). Level held high gives one event only.
- States:
  - IDLE:
    - Counters hold.
    - On I_arm rising edge (I_arm=1, prev=0): clear O_trig_count and O_missed, go ARMED.
  - ARMED:
    - On event: if I_delay==0 go PULSE, else go DELAY with delay counter=0.
  - DELAY:
    - Counter increments each cycle.
    - When counter==I_delay-1, go PULSE.
  - PULSE:
    - O_trig_out=1, width counter runs max(I_pulse_len,1) cycles.
    - On exit, O_trig_count increments.
    - If the new count >= max(I_num_trigs,1), go DONE; else go ARMED.
  - DONE:
    - O_done=1.
    - When I_arm is low, go IDLE.
    - O_trig_count and O_missed hold until the next arm.
- Latency: event sampled at edge N. O_trig_out rises at edge N+1+D and stays high exactly max(W,1) cycles.
- Event arriving in DELAY or PULSE: O_missed increments, saturating at all-ones; no queueing.
- Event on the final PULSE cycle: counted missed. Re-arm detection starts the cycle after the return to ARMED.
- I_arm low in ARMED/DELAY/PULSE: next edge goes to IDLE, O_trig_out=0 and O_trig_count holds. I_arm rising again starts a fresh session.
- I_delay, I_pulse_len and I_num_trigs are sampled live. Software only changes them in IDLE; behaviour on a mid-session change is undefined except that the FSM always exits (compare uses ==, so the counter also terminates at wrap).
- Passthru = 1:
  - O_trig_out = I_m3_trig registered, 1 cycle latency.
  - FSM forced to IDLE; O_arm_active, O_capturing and O_done are 0.
  - Arm edges are ignored.
- Passthru falling: FSM resumes in IDLE. A new I_arm rising edge is required.
- Synchronous reset overrides everything, including mid-pulse: O_trig_out is 0 after that edge.

Optional Feature:
- Macro TRIG_SEQ_TIMESTAMP_EN.
- When defined:
  - Adds a free-running 32-bit counter, cleared on reset and on session start.
  - Adds output O_trig_timestamp [31:0], latched with the counter value on the cycle O_trig_out rises, holding until the next rise; 0 after reset.
  - Passthru rises also latch it.
- When not defined: the port and counter are absent; everything else is identical.

Test Plan:
- Arm, I_delay=0, I_pulse_len=4, I_num_trigs=1, trace_trig pulse at edge 10 -> O_trig_out high edges 11-14, O_done at 15, O_trig_count=1.
- I_delay=5, I_pulse_len=0, I_num_trigs=3, events at 10, 30, 50 -> 1-cycle pulses at 16, 36, 56; O_done after the third pulse; count=3.
- I_delay=10, events at 10 and 13 -> one pulse at 21, O_missed=1. Event held high for 20 cycles -> one event only.
- Arm, event, deassert I_arm in DELAY -> no pulse, IDLE next cycle. Re-arm -> counts cleared and a fresh pulse works.
- Passthru=1, I_m3_trig toggling, arm pulsed -> O_trig_out equals I_m3_trig delayed 1 cycle; status outputs stay 0. Reset asserted mid-PULSE -> all outputs 0 the next cycle.
- With TRIG_SEQ_TIMESTAMP_EN: arm at cycle 0, event at 100, delay 7 -> O_trig_timestamp=108 (counter value at pulse rise).

Source files
------------

// File: rtl/trace_trig_sequencer.sv
// Arm-session trigger sequencer: event edge -> programmable delay -> programmable-width pulse, N times per arm.
// Optional timestamp output enabled by defining TRIG_SEQ_TIMESTAMP_EN.
module trace_trig_sequencer #(
    parameter int pDELAY_WIDTH = 16,
    parameter int pPULSE_WIDTH = 16,
    parameter int pCOUNT_WIDTH = 8
) (
    input  logic                    trace_clk_in,
    input  logic                    reset,
    input  logic                    I_arm,
    input  logic                    I_soft_trig_passthru,
    input  logic                    I_trace_trig,
    input  logic                    I_m3_trig,
    input  logic [pDELAY_WIDTH-1:0] I_delay,
    input  logic [pPULSE_WIDTH-1:0] I_pulse_len,
    input  logic [pCOUNT_WIDTH-1:0] I_num_trigs,
    output logic                    O_trig_out,
    output logic                    O_arm_active,
    output logic                    O_capturing,
    output logic                    O_done,
    output logic [pCOUNT_WIDTH-1:0] O_trig_count,
`ifdef TRIG_SEQ_TIMESTAMP_EN
    output logic [31:0]             O_trig_timestamp,
`endif
    output logic [pCOUNT_WIDTH-1:0] O_missed
);

    typedef enum logic [2:0] {IDLE, ARMED, DELAY, PULSE, DONE} state_t;

    localparam logic [pDELAY_WIDTH-1:0] DLY_ONE = 1;
    localparam logic [pPULSE_WIDTH-1:0] PLS_ONE = 1;
    localparam logic [pCOUNT_WIDTH-1:0] CNT_ONE = 1;
    localparam logic [pCOUNT_WIDTH:0]   CNT_ONE_X = 1;

    state_t                  state;
    logic                    trace_prev;
    logic                    arm_prev;
    logic [pDELAY_WIDTH-1:0] dly_cnt;
    logic [pPULSE_WIDTH-1:0] wid_cnt;

    logic                    trig_event;
    logic                    arm_rise;
    logic                    busy;
    logic                    trig_next;
    logic                    session_start;
    logic [pPULSE_WIDTH-1:0] pulse_last;
    logic [pCOUNT_WIDTH:0]   count_inc;
    logic [pCOUNT_WIDTH:0]   num_eff;

    function automatic logic [pCOUNT_WIDTH-1:0] sat_inc(input logic [pCOUNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    assign trig_event    = I_trace_trig & ~trace_prev;
    assign arm_rise      = I_arm & ~arm_prev;
    assign busy          = (state == DELAY) || (state == PULSE);
    assign pulse_last    = (I_pulse_len == '0) ? '0 : I_pulse_len - PLS_ONE;
    assign count_inc     = {1'b0, O_trig_count} + CNT_ONE_X;
    assign num_eff       = (I_num_trigs == '0) ? CNT_ONE_X : {1'b0, I_num_trigs};
    assign trig_next     = I_soft_trig_passthru ? I_m3_trig : (I_arm && state == PULSE);
    assign session_start = !I_soft_trig_passthru && state == IDLE && arm_rise;

    always_ff @(posedge trace_clk_in) begin
        if (reset) begin
            state        <= IDLE;
            trace_prev   <= 1'b0;
            arm_prev     <= 1'b0;
            dly_cnt      <= '0;
            wid_cnt      <= '0;
            O_trig_out   <= 1'b0;
            O_arm_active <= 1'b0;
            O_capturing  <= 1'b0;
            O_done       <= 1'b0;
            O_trig_count <= '0;
            O_missed     <= '0;
        end else begin
            trace_prev <= I_trace_trig;
            arm_prev   <= I_arm;
            O_trig_out <= trig_next;
            if (I_soft_trig_passthru) begin
                state        <= IDLE;
                O_arm_active <= 1'b0;
                O_capturing  <= 1'b0;
                O_done       <= 1'b0;
            end else begin
                // status flags reflect the state held during this cycle; arm low clears them at once
                O_arm_active <= I_arm && (state == ARMED || busy);
                O_capturing  <= I_arm && busy;
                O_done       <= I_arm && state == DONE;
                if (I_arm && busy && trig_event)
                    O_missed <= sat_inc(O_missed);
                case (state)
                    IDLE: begin
                        if (arm_rise) begin
                            O_trig_count <= '0;
                            O_missed     <= '0;
                            state        <= ARMED;
                        end
                    end
                    ARMED: begin
                        if (!I_arm) begin
                            state <= IDLE;
                        end else if (trig_event) begin
                            dly_cnt <= '0;
                            wid_cnt <= '0;
                            state   <= (I_delay == '0) ? PULSE : DELAY;
                        end
                    end
                    DELAY: begin
                        if (!I_arm) begin
                            state <= IDLE;
                        end else if (dly_cnt == I_delay - DLY_ONE) begin
                            wid_cnt <= '0;
                            state   <= PULSE;
                        end else begin
                            dly_cnt <= dly_cnt + DLY_ONE;
                        end
                    end
                    PULSE: begin
                        if (!I_arm) begin
                            state <= IDLE;
                        end else if (wid_cnt == pulse_last) begin
                            O_trig_count <= count_inc[pCOUNT_WIDTH-1:0];
                            state        <= (count_inc >= num_eff) ? DONE : ARMED;
                        end else begin
                            wid_cnt <= wid_cnt + PLS_ONE;
                        end
                    end
                    DONE: begin
                        if (!I_arm)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef TRIG_SEQ_TIMESTAMP_EN
    logic [31:0] ts_cnt;
    logic [31:0] ts_next;

    assign ts_next = session_start ? 32'd0 : ts_cnt + 32'd1;

    // stamp carries the counter value taken on the same edge the pulse rises
    always_ff @(posedge trace_clk_in) begin
        if (reset) begin
            ts_cnt           <= 32'd0;
            O_trig_timestamp <= 32'd0;
        end else begin
            ts_cnt <= ts_next;
            if (trig_next && !O_trig_out)
                O_trig_timestamp <= ts_next;
        end
    end
`else
    logic unused_start;
    assign unused_start = session_start;
`endif

endmodule

// File: tb/tb_trace_trig_sequencer.sv
// Randomized plus directed bench for trace_trig_sequencer against an interval-based session model.
module tb_trace_trig_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        arm, pt, tt, m3;
    logic [15:0] dly, plen;
    logic [7:0]  ntrig;
    logic        trig_out, arm_active, capturing, done;
    logic [7:0]  trig_count, missed;
`ifdef TRIG_SEQ_TIMESTAMP_EN
    logic [31:0] tstamp;
`endif

    always #5 clk = ~clk;

    trace_trig_sequencer dut (
        .trace_clk_in        (clk),
        .reset               (reset),
        .I_arm               (arm),
        .I_soft_trig_passthru(pt),
        .I_trace_trig        (tt),
        .I_m3_trig           (m3),
        .I_delay             (dly),
        .I_pulse_len         (plen),
        .I_num_trigs         (ntrig),
        .O_trig_out          (trig_out),
        .O_arm_active        (arm_active),
        .O_capturing         (capturing),
        .O_done              (done),
        .O_trig_count        (trig_count),
`ifdef TRIG_SEQ_TIMESTAMP_EN
        .O_trig_timestamp    (tstamp),
`endif
        .O_missed            (missed)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    endtask

    // session model: phase 0 idle, 1 in session, 2 finished; a busy window spans event+1 .. event+D+W
    int m_phase, m_evt, m_d, m_end, m_cnt, m_missed;
    bit m_busy, m_tprev, m_aprev;
    int e_trig, e_arm, e_cap, e_done;
    int m_ts_cnt, m_ts;

    task automatic model_step();
        bit ev, ar;
        int wid, num, prev_trig, was_idle;
        prev_trig = e_trig;
        was_idle  = (m_phase == 0) ? 1 : 0;
        if (reset) begin
            m_phase = 0; m_busy = 0; m_cnt = 0; m_missed = 0;
            m_tprev = 0; m_aprev = 0;
            e_trig = 0; e_arm = 0; e_cap = 0; e_done = 0;
            m_ts_cnt = 0; m_ts = 0;
            return;
        end
        ev = tt && !m_tprev;
        ar = arm && !m_aprev;
        m_tprev = tt;
        m_aprev = arm;
        m_ts_cnt = (!pt && was_idle == 1 && ar) ? 0 : m_ts_cnt + 1;
        if (pt) begin
            m_phase = 0; m_busy = 0;
            e_trig = int'(m3); e_arm = 0; e_cap = 0; e_done = 0;
        end else begin
            e_arm  = (arm && m_phase == 1) ? 1 : 0;
            e_cap  = (arm && m_phase == 1 && m_busy) ? 1 : 0;
            e_trig = (arm && m_phase == 1 && m_busy && cyc > m_evt + m_d) ? 1 : 0;
            e_done = (arm && m_phase == 2) ? 1 : 0;
            wid = (plen == 0) ? 1 : int'(plen);
            num = (ntrig == 0) ? 1 : int'(ntrig);
            case (m_phase)
                0: if (ar) begin m_cnt = 0; m_missed = 0; m_phase = 1; m_busy = 0; end
                1: begin
                    if (!arm) begin
                        m_phase = 0; m_busy = 0;
                    end else if (m_busy) begin
                        if (ev && m_missed < 255) m_missed++;
                        if (cyc == m_end) begin
                            m_busy = 0;
                            m_cnt++;
                            if (m_cnt >= num) m_phase = 2;
                        end
                    end else if (ev) begin
                        m_busy = 1; m_evt = cyc; m_d = int'(dly); m_end = cyc + int'(dly) + wid;
                    end
                end
                default: if (!arm) m_phase = 0;
            endcase
        end
        if (e_trig == 1 && prev_trig == 0) m_ts = m_ts_cnt;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        check("trig_out",   int'(trig_out),   e_trig);
        check("arm_active", int'(arm_active), e_arm);
        check("capturing",  int'(capturing),  e_cap);
        check("done",       int'(done),       e_done);
        check("trig_count", int'(trig_count), m_cnt);
        check("missed",     int'(missed),     m_missed);
`ifdef TRIG_SEQ_TIMESTAMP_EN
        check("timestamp",  int'(tstamp),     m_ts);
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic fire();
        tt = 1'b1; step();
        tt = 1'b0; step();
    endtask

    task automatic start_session(input int d, input int w, input int n);
        arm = 1'b0; dly = 16'(d); plen = 16'(w); ntrig = 8'(n);
        idle(2);
        arm = 1'b1;
        idle(2);
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; pt = 1'b0; tt = 1'b0; m3 = 1'b0;
        dly = 16'd0; plen = 16'd1; ntrig = 8'd1;
        idle(2);
        check("reset_trig",  int'(trig_out),   0);
        check("reset_count", int'(trig_count), 0);
        reset = 1'b0;

        // single zero-delay pulse of width 4
        start_session(0, 4, 1);
        fire();
        idle(6);
        check("t1_count", int'(trig_count), 1);
        check("t1_done",  int'(done),       1);

        // three one-cycle pulses after delay 5
        start_session(5, 0, 3);
        repeat (3) begin fire(); idle(18); end
        check("t2_count", int'(trig_count), 3);
        check("t2_done",  int'(done),       1);

        // second event inside the delay is missed; held level is one event
        start_session(10, 1, 2);
        fire(); idle(1); fire();
        idle(15);
        check("t3_missed", int'(missed), 1);
        tt = 1'b1; idle(20); tt = 1'b0;
        idle(5);
        check("t3_count", int'(trig_count), 2);

        // abort during delay, then re-arm
        start_session(10, 2, 1);
        fire(); idle(3);
        arm = 1'b0; step();
        check("t4_abort_cap", int'(capturing), 0);
        idle(12);
        check("t4_no_pulse", int'(trig_count), 0);
        arm = 1'b1; idle(2);
        fire(); idle(16);
        check("t4_rearm", int'(trig_count), 1);

        // passthrough with arm activity, then reset mid-pulse
        pt = 1'b1;
        for (int i = 0; i < 24; i++) begin
            m3 = 1'($urandom_range(0, 1));
            if (i % 6 == 0) arm = ~arm;
            step();
        end
        pt = 1'b0; m3 = 1'b0;
        start_session(0, 8, 1);
        fire(); idle(2);
        reset = 1'b1; step();
        check("t5_rst_trig", int'(trig_out), 0);
        reset = 1'b0; arm = 1'b0; idle(3);

        // randomized sessions
        for (int s = 0; s < 40; s++) begin
            start_session(int'($urandom_range(0, 12)), int'($urandom_range(0, 5)),
                          int'($urandom_range(0, 3)));
            pt = ($urandom_range(0, 5) == 0);
            for (int i = 0; i < 70; i++) begin
                if ($urandom_range(0, 6) == 0) tt = ~tt;
                m3 = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 120) == 0) arm = ~arm;
                if (pt && $urandom_range(0, 30) == 0) pt = 1'b0;
                reset = ($urandom_range(0, 300) == 0);
                step();
            end
            reset = 1'b0; pt = 1'b0; tt = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
